// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream raster test-pattern source (ramp, grid, colour bars, coordinate code).
// Optional: define PATTERN_GEN_FRAME_STAMP_EN to stamp frame_cnt into pixel (0,0) of every frame.
module axis_video_pattern_gen #(
  parameter int WIDTH       = 1920,
  parameter int HEIGHT      = 1080,
  parameter int DATA_WIDTH  = 24,
  parameter int COORD_WIDTH = 16,
  parameter int HBLANK      = 0,
  parameter int VBLANK      = 0,
  parameter int GRID_STEP   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt
);

  // Handshake: a beat moves when tvalid && tready at a rising edge; while tvalid is
  // high and tready is low, tdata/tlast/tuser are held and tvalid never drops.

  localparam int BAR_W = WIDTH / 8;
  localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(HEIGHT - 1);
  localparam logic [COORD_WIDTH-1:0] G_LAST = COORD_WIDTH'(GRID_STEP - 1);
  localparam logic [COORD_WIDTH-1:0] B_LAST = COORD_WIDTH'(BAR_W - 1);
  localparam logic [15:0]            HB_LOAD = 16'(HBLANK - 1);
  localparam logic [15:0]            VB_LOAD = 16'(VBLANK - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HBLANK = 2'd2,
    S_VBLANK = 2'd3
  } state_t;

  state_t state_q, state_n;

  // Coordinates of the pixel currently presented (or next to present after a blank).
  logic [COORD_WIDTH-1:0] x_q, x_n, y_q, y_n;
  logic [COORD_WIDTH-1:0] gx_q, gx_n, gy_q, gy_n;
  logic [COORD_WIDTH-1:0] bpos_q, bpos_n;
  logic [2:0]             bar_q, bar_n;
  logic [1:0]             pat_q, pat_n;
  logic [15:0]            blank_q, blank_n;

  logic [DATA_WIDTH-1:0]  tdata_q, tdata_n;
  logic                   tvalid_q, tvalid_n, tlast_q, tlast_n, tuser_q, tuser_n;
  logic                   done_q, done_n, busy_q, busy_n;
  logic [15:0]            cnt_q, cnt_n;
  logic                   load, start, stop;

  function automatic logic [DATA_WIDTH-1:0] pixel(
    input logic [1:0]             pat,
    input logic [COORD_WIDTH-1:0] px,
    input logic [COORD_WIDTH-1:0] py,
    input logic [COORD_WIDTH-1:0] pgx,
    input logic [COORD_WIDTH-1:0] pgy,
    input logic [2:0]             pbar
  );
    logic [23:0] rgb;
    case (pat)
      2'd0: rgb = {8'(px), 8'(px), 8'(px)};
      2'd1: rgb = (pgx == '0 || pgy == '0) ? 24'hFFFFFF : 24'h000000;
      2'd2: begin
        case (pbar)
          3'd0:    rgb = 24'hFFFFFF;
          3'd1:    rgb = 24'hFFFF00;
          3'd2:    rgb = 24'h00FFFF;
          3'd3:    rgb = 24'h00FF00;
          3'd4:    rgb = 24'hFF00FF;
          3'd5:    rgb = 24'hFF0000;
          3'd6:    rgb = 24'h0000FF;
          default: rgb = 24'h000000;
        endcase
      end
      default: rgb = {12'(py), 12'(px)};
    endcase
    return DATA_WIDTH'(rgb);
  endfunction

  always_comb begin
    state_n  = state_q;
    x_n      = x_q;
    y_n      = y_q;
    gx_n     = gx_q;
    gy_n     = gy_q;
    bpos_n   = bpos_q;
    bar_n    = bar_q;
    pat_n    = pat_q;
    blank_n  = blank_q;
    tdata_n  = tdata_q;
    tvalid_n = tvalid_q;
    tlast_n  = tlast_q;
    tuser_n  = tuser_q;
    done_n   = 1'b0;
    cnt_n    = cnt_q;
    load     = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) start = 1'b1;
      end
      S_ACTIVE: begin
        if (m_axis_tready) begin
          if (x_q != X_LAST) begin
            x_n  = x_q + 1'b1;
            gx_n = (gx_q == G_LAST) ? '0 : gx_q + 1'b1;
            if (bpos_q == B_LAST) begin
              bpos_n = '0;
              if (bar_q != 3'd7) bar_n = bar_q + 3'd1;
            end else begin
              bpos_n = bpos_q + 1'b1;
            end
            load = 1'b1;
          end else begin
            x_n    = '0;
            gx_n   = '0;
            bpos_n = '0;
            bar_n  = 3'd0;
            if (y_q != Y_LAST) begin
              y_n  = y_q + 1'b1;
              gy_n = (gy_q == G_LAST) ? '0 : gy_q + 1'b1;
              if (HBLANK > 0) begin
                state_n = S_HBLANK;
                blank_n = HB_LOAD;
                stop    = 1'b1;
              end else begin
                load = 1'b1;
              end
            end else begin
              y_n    = '0;
              gy_n   = '0;
              done_n = 1'b1;
              cnt_n  = cnt_q + 16'd1;
              if (VBLANK > 0) begin
                state_n = S_VBLANK;
                blank_n = VB_LOAD;
                stop    = 1'b1;
              end else if (enable) begin
                start = 1'b1;
              end else begin
                state_n = S_IDLE;
                stop    = 1'b1;
              end
            end
          end
        end
      end
      S_HBLANK: begin
        if (blank_q == 16'd0) begin
          state_n = S_ACTIVE;
          load    = 1'b1;
        end else begin
          blank_n = blank_q - 16'd1;
        end
      end
      default: begin
        if (blank_q != 16'd0) begin
          blank_n = blank_q - 16'd1;
        end else if (enable) begin
          start = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
    endcase

    if (start) begin
      state_n = S_ACTIVE;
      x_n     = '0;
      y_n     = '0;
      gx_n    = '0;
      gy_n    = '0;
      bpos_n  = '0;
      bar_n   = 3'd0;
      pat_n   = pattern_sel;
      load    = 1'b1;
    end

    if (stop) begin
      tvalid_n = 1'b0;
      tlast_n  = 1'b0;
      tuser_n  = 1'b0;
    end

    if (load) begin
      tvalid_n = 1'b1;
      tlast_n  = (x_n == X_LAST);
      tuser_n  = (x_n == '0) && (y_n == '0);
      tdata_n  = pixel(pat_n, x_n, y_n, gx_n, gy_n, bar_n);
`ifdef PATTERN_GEN_FRAME_STAMP_EN
      // cnt_n already counts a frame that completes on this same edge.
      if (x_n == '0 && y_n == '0) tdata_n = DATA_WIDTH'(cnt_n);
`endif
    end

    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      gx_q     <= '0;
      gy_q     <= '0;
      bpos_q   <= '0;
      bar_q    <= 3'd0;
      pat_q    <= 2'd0;
      blank_q  <= 16'd0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= 16'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      x_q      <= x_n;
      y_q      <= y_n;
      gx_q     <= gx_n;
      gy_q     <= gy_n;
      bpos_q   <= bpos_n;
      bar_q    <= bar_n;
      pat_q    <= pat_n;
      blank_q  <= blank_n;
      tdata_q  <= tdata_n;
      tvalid_q <= tvalid_n;
      tlast_q  <= tlast_n;
      tuser_q  <= tuser_n;
      done_q   <= done_n;
      cnt_q    <= cnt_n;
      busy_q   <= busy_n;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign frame_cnt     = cnt_q;

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Bench for axis_video_pattern_gen: three instances (8x4 main, 8x4 with blanking, 16x8 grid/bars).
`timescale 1ns/1ps
module tb_axis_video_pattern_gen;
  localparam int DW = 24;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // ---------------- instances ----------------
  logic en0 = 1'b0, rdy0 = 1'b1, rand_rdy = 1'b0;
  logic [1:0] ps0 = 2'd0;
  logic [DW-1:0] d0;
  logic v0, l0, us0, b0, fd0;
  logic [15:0] fc0;
  axis_video_pattern_gen #(.WIDTH(8), .HEIGHT(4)) u0 (
    .clk(clk), .rst_n(rst_n), .enable(en0), .pattern_sel(ps0),
    .m_axis_tdata(d0), .m_axis_tvalid(v0), .m_axis_tlast(l0), .m_axis_tuser(us0),
    .m_axis_tready(rdy0), .busy(b0), .frame_done(fd0), .frame_cnt(fc0));

  logic en1 = 1'b0, rdy1 = 1'b1;
  logic [1:0] ps1 = 2'd0;
  logic [DW-1:0] d1;
  logic v1, l1, us1, b1, fd1;
  logic [15:0] fc1;
  axis_video_pattern_gen #(.WIDTH(8), .HEIGHT(4), .HBLANK(3), .VBLANK(5)) u1 (
    .clk(clk), .rst_n(rst_n), .enable(en1), .pattern_sel(ps1),
    .m_axis_tdata(d1), .m_axis_tvalid(v1), .m_axis_tlast(l1), .m_axis_tuser(us1),
    .m_axis_tready(rdy1), .busy(b1), .frame_done(fd1), .frame_cnt(fc1));

  logic en2 = 1'b0, rdy2 = 1'b1;
  logic [1:0] ps2 = 2'd0;
  logic [DW-1:0] d2;
  logic v2, l2, us2, b2, fd2;
  logic [15:0] fc2;
  axis_video_pattern_gen #(.WIDTH(16), .HEIGHT(8), .GRID_STEP(4)) u2 (
    .clk(clk), .rst_n(rst_n), .enable(en2), .pattern_sel(ps2),
    .m_axis_tdata(d2), .m_axis_tvalid(v2), .m_axis_tlast(l2), .m_axis_tuser(us2),
    .m_axis_tready(rdy2), .busy(b2), .frame_done(fd2), .frame_cnt(fc2));

  // ---------------- check helper and pattern model ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] bar_colour(input int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [DW-1:0] exp_pix(input int pat, input int x, input int y,
                                            input int w, input int step, input int fnum);
    logic [23:0] rgb;
    int bi;
    case (pat)
      0: rgb = {3{8'(x % 256)}};
      1: rgb = ((x % step) == 0 || (y % step) == 0) ? 24'hFFFFFF : 24'h000000;
      2: begin
        bi = x / (w / 8);
        if (bi > 7) bi = 7;
        rgb = bar_colour(bi);
      end
      default: rgb = {12'(y % 4096), 12'(x % 4096)};
    endcase
`ifdef PATTERN_GEN_FRAME_STAMP_EN
    if (x == 0 && y == 0) rgb = {8'h00, 16'(fnum)};
`endif
    return rgb;
  endfunction

  // ---------------- scoreboard for u0 ----------------
  logic [DW+1:0] exp_q[$];   // {tuser, tlast, tdata}
  int mf0 = 0;
  int beats0 = 0;
  int done0 = 0;
  logic pv = 1'b0, pr = 1'b0, have_prev = 1'b0;
  logic [DW+1:0] pbeat = '0;

  task automatic push_frame0(input int pat);
    for (int n = 0; n < 32; n++)
      exp_q.push_back({(n == 0), ((n % 8) == 7), exp_pix(pat, n % 8, n / 8, 8, 64, mf0)});
    mf0++;
  endtask

  // tready driver for u0: constant 1, or random when rand_rdy is set
  always @(posedge clk) begin
    #1;
    rdy0 = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // compare process: inputs settle at posedge+1, so values seen here are what the next edge uses
  always @(negedge clk) begin
    if (!rst_n) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev && pv && !pr)
        check("u0_hold", {v0, us0, l0, d0}, {1'b1, pbeat});
      if (v0 && rdy0) begin : pop_blk
        logic [DW+1:0] e;
        if (exp_q.size() == 0) begin
          check("u0_unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("u0_beat", {us0, l0, d0}, e);
        end
        beats0++;
      end
      if (fd0) done0++;
      pv = v0;
      pr = rdy0;
      pbeat = {us0, l0, d0};
      have_prev = 1'b1;
    end
  end

  // capture for u2: frames are exactly 128 beats, so index by position in frame
  logic [DW-1:0] cap2[128];
  int cnt2 = 0;
  always @(negedge clk) begin
    if (rst_n && v2 && rdy2) begin
      cap2[cnt2 % 128] = d2;
      cnt2++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done0(input int target, input string name);
    int k = 0;
    while (done0 < target && k < 2000) begin @(negedge clk); k++; end
    check(name, 32'(done0 >= target), 32'd1);
  endtask

  task automatic wait_beats0(input int n);
    int k = 0;
    while (beats0 < n && k < 1000) begin @(negedge clk); k++; end
    check("u0_wait_beats", 32'(beats0 >= n), 32'd1);
  endtask

  task automatic wait_cnt2(input int n);
    int k = 0;
    while (cnt2 < n && k < 1000) begin @(negedge clk); k++; end
    check("u2_wait_beats", 32'(cnt2 >= n), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    int base;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_tvalid", {v0, v1, v2}, 3'b000);
    check("rst_tdata", d0, 0);
    check("rst_flags", {l0, us0, b0, fd0}, 4'b0000);
    check("rst_frame_cnt", fc0, 0);
    check("rst_busy_all", {b1, b2}, 2'b00);

    // test 1: single pulse, pattern 3, tready=1
    @(posedge clk); #1;
    ps0 = 2'd3; en0 = 1'b1;
    push_frame0(3);
    @(posedge clk); #1;
    en0 = 1'b0;
    @(negedge clk);
    check("t1_first_beat", {v0, us0}, 2'b11);
    check("t1_first_data", d0, exp_pix(3, 0, 0, 8, 64, 0));
    wait_done0(1, "t1_frame_done");
    repeat (3) @(negedge clk);
    check("t1_frame_cnt", fc0, 1);
    check("t1_idle", {v0, b0}, 2'b00);
    check("t1_done_pulses", done0, 1);
    check("t1_queue_empty", exp_q.size(), 0);
    // hand-computed pins of the coordinate model: beat 13 -> (5,1), beat 31 -> (7,3)
    check("pin_coord_13", exp_pix(3, 5, 1, 8, 64, 3), 24'h001005);
    check("pin_coord_31", exp_pix(3, 7, 3, 8, 64, 3), 24'h003007);

    // test 2: random tready
    rand_rdy = 1'b1;
    @(posedge clk); #1;
    ps0 = 2'd3; en0 = 1'b1;
    push_frame0(3);
    @(posedge clk); #1;
    en0 = 1'b0;
    wait_done0(2, "t2_frame_done");
    rand_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("t2_frame_cnt", fc0, 2);
    check("t2_queue_empty", exp_q.size(), 0);

    // test 3: blanking on u1, enable held across two frames, pattern 0
    @(posedge clk); #1;
    ps1 = 2'd0; en1 = 1'b1;
    for (k = 0; k < 20 && !v1; k++) @(negedge clk);
    check("u1_start", v1, 1);
    for (int l = 0; l < 4; l++) begin
      for (int x = 0; x < 8; x++) begin
        check("u1_valid", v1, 1);
        check("u1_last", l1, 32'(x == 7));
        check("u1_user", us1, 32'(l == 0 && x == 0));
        check("u1_data", d1, exp_pix(0, x, l, 8, 64, 0));
        @(negedge clk);
      end
      for (int g = 0; g < ((l < 3) ? 3 : 5); g++) begin
        check("u1_gap", v1, 0);
        check("u1_frame_done", fd1, 32'(l == 3 && g == 0));
        @(negedge clk);
      end
    end
    check("u1_second_sof", {v1, us1}, 2'b11);
    check("u1_frame_cnt_1", fc1, 1);
    @(posedge clk); #1;
    en1 = 1'b0;
    k = 0;
    while (!fd1 && k < 200) begin @(negedge clk); k++; end
    check("u1_frame2_done", fd1, 1);
    @(negedge clk);
    check("u1_frame_cnt_2", fc1, 2);
    check("pin_ramp", exp_pix(0, 6, 2, 8, 64, 0), 24'h060606);

    // test 4: grid and bars on u2
    @(posedge clk); #1;
    ps2 = 2'd1; en2 = 1'b1;
    @(posedge clk); #1;
    en2 = 1'b0;
    wait_cnt2(128);
    check("grid_4_1", cap2[20], 24'hFFFFFF);
    check("grid_5_1", cap2[21], 24'h000000);
    check("grid_5_0", cap2[5], 24'hFFFFFF);
    check("grid_5_4", cap2[69], 24'hFFFFFF);
    for (int i = 0; i < 128; i++)
      check("grid_model", cap2[i], exp_pix(1, i % 16, i / 16, 16, 4, 0));
    @(posedge clk); #1;
    ps2 = 2'd2; en2 = 1'b1;
    @(posedge clk); #1;
    en2 = 1'b0;
    wait_cnt2(256);
    check("bars_x0", cap2[16], 24'hFFFFFF);
    check("bars_x1", cap2[17], 24'hFFFFFF);
    check("bars_x2", cap2[18], 24'hFFFF00);
    check("bars_x15", cap2[31], 24'h000000);
    for (int i = 0; i < 128; i++)
      check("bars_model", cap2[i], exp_pix(2, i % 16, i / 16, 16, 4, 1));
    repeat (3) @(negedge clk);
    check("u2_frame_cnt", fc2, 2);

    // test 5: enable dropped and pattern changed mid-frame
    base = beats0;
    @(posedge clk); #1;
    ps0 = 2'd3; en0 = 1'b1;
    push_frame0(3);
    wait_beats0(base + 10);
    @(posedge clk); #1;
    en0 = 1'b0; ps0 = 2'd0;
    wait_done0(3, "t5_frame_done");
    repeat (5) @(negedge clk);
    check("t5_idle", {v0, b0}, 2'b00);
    check("t5_frame_cnt", fc0, 3);
    check("t5_queue_empty", exp_q.size(), 0);
    check("t5_beats", beats0 - base, 32);

    // test 6: async reset mid-frame
    base = beats0;
    @(posedge clk); #1;
    ps0 = 2'd3; en0 = 1'b1;
    push_frame0(3);
    wait_beats0(base + 20);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_tvalid", v0, 0);
    check("t6_rst_frame_cnt", fc0, 0);
    check("t6_rst_busy", b0, 0);
    exp_q.delete();
    mf0 = 0;
    push_frame0(3);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    en0 = 1'b0;
    @(negedge clk);
    check("t6_first_beat", {v0, us0}, 2'b11);
    wait_done0(4, "t6_frame_done");
    repeat (3) @(negedge clk);
    check("t6_frame_cnt", fc0, 1);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
